branch_decode_stage: RTL and testbench

- ID-side partner of the instruction fetch stage: latches fetched instruction/PC into the IF/ID register and decodes B, CBZ and B.LT.
- Resolves each branch against forwarded operands/flags, then drives BrTaken, UncondBr and a branch target back to fetch.
- Stalls fetch (pcWrite low) while a branch operand is not yet valid.
- One architectural delay slot: the instruction after a branch always executes; taken branches are never flushed by this block.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_target_calc.sv | 24 ++
 rtl/branch_decode_stage.sv | 122 ++++++++++++
 tb/tb_branch_decode_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - opcode constants, state and branch-kind types for the ID branch stage
package branch_pkg;

  localparam logic [5:0]  OP_B      = 6'b000101;
  localparam logic [7:0]  OP_CBZ    = 8'b10110100;
  localparam logic [7:0]  OP_BCOND  = 8'b01010100;
  localparam logic [4:0]  COND_LT   = 5'h0B;
  localparam logic [31:0] NOP_INSTR = 32'h8B1F03FF;

  typedef enum logic {RUN, WAIT} state_t;

  typedef enum logic [1:0] {BR_NONE, BR_B, BR_CBZ, BR_BLT} br_kind_t;

  // B.cond with any condition other than LT is treated as an ordinary instruction.
  function automatic br_kind_t decode_branch(input logic [31:0] instr);
    if (instr[31:26] == OP_B)
      return BR_B;
    else if (instr[31:24] == OP_CBZ)
      return BR_CBZ;
    else if (instr[31:24] == OP_BCOND && instr[4:0] == COND_LT)
      return BR_BLT;
    else
      return BR_NONE;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - idPC plus sign-extended word offset, chosen by branch kind
module branch_target_calc
  import branch_pkg::*;
(
  input  br_kind_t    i_kind,
  input  logic [25:0] i_imm,
  input  logic [63:0] i_pc,
  output logic [63:0] o_target
);

  logic [63:0] w_offset;

  always_comb begin
    w_offset = 64'd0;
    case (i_kind)
      BR_B:            w_offset = {{36{i_imm[25]}}, i_imm[25:0], 2'b00};
      BR_CBZ, BR_BLT:  w_offset = {{43{i_imm[23]}}, i_imm[23:5], 2'b00};
      default:         w_offset = 64'd0;
    endcase
  end

  assign o_target = i_pc + w_offset;

endmodule

// File: rtl/branch_decode_stage.sv
// rtl/branch_decode_stage.sv - IF/ID register, branch decode/resolve and operand-wait stall
module branch_decode_stage
  import branch_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic [63:0]          currentPC,
  input  logic                 flush,
  input  logic                 hazardHold,
  input  logic [63:0]          cbzOperand,
  input  logic                 cbzOperandValid,
  input  logic                 flagN,
  input  logic                 flagV,
  input  logic                 flagsValid,
  output logic                 BrTaken,
  output logic                 UncondBr,
  output logic [63:0]          branchTarget,
  output logic                 pcWrite,
  output logic [31:0]          idInstruction,
  output logic [63:0]          idPC,
  output logic                 idValid,
  output logic [CNT_WIDTH-1:0] takenCount
);

  logic [31:0]          r_instr;
  logic [63:0]          r_pc;
  logic                 r_valid;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;

  br_kind_t w_kind;
  logic     w_ready;
  logic     w_cond;
  logic     w_taken;
  logic     w_uncond;
  logic     w_pcwrite;
  logic     w_hold;
  state_t   w_next;

  branch_target_calc u_target (
    .i_kind   (w_kind),
    .i_imm    (r_instr[25:0]),
    .i_pc     (r_pc),
    .o_target (branchTarget)
  );

  always_comb begin
    w_kind    = r_valid ? decode_branch(r_instr) : BR_NONE;
    w_ready   = 1'b1;
    w_cond    = 1'b0;
    w_taken   = 1'b0;
    w_uncond  = 1'b0;
    w_pcwrite = 1'b1;
    w_hold    = 1'b0;
    w_next    = r_state;

    case (w_kind)
      BR_B:    w_cond = 1'b1;
      BR_CBZ:  begin w_cond = (cbzOperand == 64'd0); w_ready = cbzOperandValid; end
      BR_BLT:  begin w_cond = flagN ^ flagV;         w_ready = flagsValid;      end
      default: w_cond = 1'b0;
    endcase

    if (reset) begin
      w_next = RUN;
    end else if (!w_ready) begin
      // Operand missing: stall fetch and freeze IF/ID until it arrives.
      w_pcwrite = 1'b0;
      w_hold    = 1'b1;
      w_next    = WAIT;
    end else if (r_state == WAIT) begin
      w_taken   = w_cond;
      w_hold    = hazardHold;
      w_next    = RUN;
    end else begin
      w_taken   = w_cond;
      w_uncond  = (w_kind == BR_B);
      w_pcwrite = ~hazardHold;
      w_hold    = hazardHold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 64'd0;
      r_valid <= 1'b0;
      r_state <= RUN;
    end else if (flush) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 64'd0;
      r_valid <= 1'b0;
      r_state <= RUN;
    end else begin
      r_state <= w_next;
      if (!w_hold) begin
        r_instr <= instruction;
        r_pc    <= currentPC;
        r_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (w_taken && w_pcwrite)
      r_cnt <= r_cnt + 1'b1;
  end

  assign BrTaken       = w_taken;
  assign UncondBr      = w_uncond;
  assign pcWrite       = w_pcwrite;
  assign idInstruction = r_instr;
  assign idPC          = r_pc;
  assign idValid       = r_valid;
  assign takenCount    = r_cnt;

endmodule

// File: tb/tb_branch_decode_stage.sv
// tb/tb_branch_decode_stage.sv - directed vector table plus stall/flush/reset/hold sequences
module tb_branch_decode_stage;

  localparam logic [31:0] NOP   = 32'h8B1F03FF;
  localparam logic [31:0] ADD   = 32'h8B020020;
  localparam logic [31:0] ADD2  = 32'h8B030041;
  localparam logic [31:0] B3    = {6'b000101, 26'd3};
  localparam logic [31:0] BM1   = {6'b000101, 26'h3FFFFFF};
  localparam logic [31:0] CBZM2 = {8'hB4, 19'h7FFFE, 5'd0};
  localparam logic [31:0] BLT4  = {8'h54, 19'd4, 5'h0B};
  localparam logic [31:0] BEQ4  = {8'h54, 19'd4, 5'h00};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [63:0] currentPC;
  logic        flush;
  logic        hazardHold;
  logic [63:0] cbzOperand;
  logic        cbzOperandValid;
  logic        flagN;
  logic        flagV;
  logic        flagsValid;
  logic        BrTaken;
  logic        UncondBr;
  logic [63:0] branchTarget;
  logic        pcWrite;
  logic [31:0] idInstruction;
  logic [63:0] idPC;
  logic        idValid;
  logic [31:0] takenCount;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_cnt;

  branch_decode_stage #(.CNT_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .instruction     (instruction),
    .currentPC       (currentPC),
    .flush           (flush),
    .hazardHold      (hazardHold),
    .cbzOperand      (cbzOperand),
    .cbzOperandValid (cbzOperandValid),
    .flagN           (flagN),
    .flagV           (flagV),
    .flagsValid      (flagsValid),
    .BrTaken         (BrTaken),
    .UncondBr        (UncondBr),
    .branchTarget    (branchTarget),
    .pcWrite         (pcWrite),
    .idInstruction   (idInstruction),
    .idPC            (idPC),
    .idValid         (idValid),
    .takenCount      (takenCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] op;
    logic        n;
    logic        v;
    logic        exp_taken;
    logic        exp_unc;
    logic        chk_tgt;
    logic [63:0] exp_tgt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load one instruction through IF/ID with operands not yet valid, ending in WAIT.
  task automatic enter_wait();
    instruction = CBZM2; currentPC = 64'h40;
    cbzOperandValid = 1'b0; cbzOperand = 64'd0;
    step();
    instruction = ADD; currentPC = 64'h44;
    #1;
    chk("wait_entry_pcwrite", pcWrite, 1'b0);
    step();
  endtask

  initial begin
    vecs[0] = '{B3,    64'h10,   64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1C};
    vecs[1] = '{CBZM2, 64'h40,   64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h38};
    vecs[2] = '{CBZM2, 64'h40,   64'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h38};
    vecs[3] = '{BLT4,  64'h100,  64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h110};
    vecs[4] = '{BLT4,  64'h100,  64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h110};
    vecs[5] = '{BLT4,  64'h100,  64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h110};
    vecs[6] = '{BEQ4,  64'h100,  64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[7] = '{BM1,   64'h1000, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'hFFC};
    vecs[8] = '{ADD,   64'h2000, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[9] = '{CBZM2, 64'h0,    64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF8};

    reset = 1'b1; flush = 1'b0; hazardHold = 1'b0;
    instruction = B3; currentPC = 64'h10;
    cbzOperand = 64'd0; cbzOperandValid = 1'b1;
    flagN = 1'b0; flagV = 1'b0; flagsValid = 1'b1;
    step();
    step();
    chk("rst_instr",  idInstruction, NOP);
    chk("rst_pc",     idPC, 64'd0);
    chk("rst_valid",  idValid, 1'b0);
    chk("rst_cnt",    takenCount, 32'd0);
    chk("rst_taken",  BrTaken, 1'b0);
    chk("rst_pcw",    pcWrite, 1'b1);

    reset = 1'b0;
    exp_cnt = 32'd0;
    for (int i = 0; i < 10; i++) begin
      instruction = vecs[i].instr; currentPC = vecs[i].pc;
      step();
      cbzOperand = vecs[i].op; flagN = vecs[i].n; flagV = vecs[i].v;
      instruction = ADD; currentPC = vecs[i].pc + 64'd4;
      #1;
      chk($sformatf("v%0d_taken", i), BrTaken, vecs[i].exp_taken);
      chk($sformatf("v%0d_unc", i),   UncondBr, vecs[i].exp_unc);
      chk($sformatf("v%0d_pcw", i),   pcWrite, 1'b1);
      chk($sformatf("v%0d_cnt", i),   takenCount, exp_cnt);
      if (vecs[i].chk_tgt)
        chk($sformatf("v%0d_tgt", i), branchTarget, vecs[i].exp_tgt);
      if (vecs[i].exp_taken) exp_cnt = exp_cnt + 1;
    end
    step();
    chk("cnt_after_table", takenCount, exp_cnt);

    // CBZ stalls three cycles, then resolves taken.
    instruction = CBZM2; currentPC = 64'h40;
    cbzOperandValid = 1'b0; cbzOperand = 64'd0;
    step();
    instruction = ADD; currentPC = 64'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_pcw", i),   pcWrite, 1'b0);
      chk($sformatf("stall%0d_taken", i), BrTaken, 1'b0);
      chk($sformatf("stall%0d_instr", i), idInstruction, CBZM2);
      step();
    end
    cbzOperandValid = 1'b1;
    #1;
    chk("resolve_taken", BrTaken, 1'b1);
    chk("resolve_pcw",   pcWrite, 1'b1);
    chk("resolve_tgt",   branchTarget, 64'h38);
    exp_cnt = exp_cnt + 1;
    step();
    chk("resolve_load",  idInstruction, ADD);
    chk("resolve_run",   pcWrite, 1'b1);
    chk("resolve_cnt",   takenCount, exp_cnt);

    // Flush during WAIT.
    enter_wait();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_instr", idInstruction, NOP);
    chk("flush_valid", idValid, 1'b0);
    chk("flush_pcw",   pcWrite, 1'b1);
    chk("flush_taken", BrTaken, 1'b0);
    step();

    // Reset during WAIT.
    enter_wait();
    chk("prerst_cnt_nonzero", (takenCount != 32'd0), 1'b1);
    reset = 1'b1;
    step();
    chk("wrst_instr", idInstruction, NOP);
    chk("wrst_pc",    idPC, 64'd0);
    chk("wrst_valid", idValid, 1'b0);
    chk("wrst_cnt",   takenCount, 32'd0);
    chk("wrst_pcw",   pcWrite, 1'b1);
    chk("wrst_taken", BrTaken, 1'b0);
    reset = 1'b0;
    cbzOperandValid = 1'b1;

    // Load-use hold with an ADD in ID.
    instruction = ADD; currentPC = 64'h200;
    step();
    instruction = ADD2; currentPC = 64'h204;
    hazardHold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("hold%0d_pcw", i),   pcWrite, 1'b0);
      chk($sformatf("hold%0d_instr", i), idInstruction, ADD);
      chk($sformatf("hold%0d_pc", i),    idPC, 64'h200);
      step();
    end
    hazardHold = 1'b0;
    #1;
    chk("unhold_pcw", pcWrite, 1'b1);
    step();
    chk("unhold_instr", idInstruction, ADD2);
    chk("unhold_pc",    idPC, 64'h204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
